data_mem: RTL and testbench
===========================

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the word-address width (memory depth 2**ADDR_W words of 32 bits).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, the number of wait-state cycles between accept and completion (range 0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port memCe  input  1  request enable from the access stage.
REQ-006 SHALL have port memWr  input  1  write request.
REQ-007 SHALL have port memRr  input  1  read request.
REQ-008 SHALL have port memAddr  input  32  byte address.
REQ-009 SHALL have port wtData  input  32  write data, byte lanes [7:0]=lane0 .. [31:24]=lane3.
REQ-010 SHALL have port w_mask  input  4  write byte-lane enables.
REQ-011 SHALL have port r_mask  input  4  read byte-lane enables.
REQ-012 SHALL have port rdData  output  32  registered read data.
REQ-013 SHALL have port memAck  output  1  one-cycle completion pulse.
REQ-014 SHALL have port memBusy  output  1  high from accept through the ack cycle inclusive; the pipeline stalls on it.
REQ-015 SHALL have port memErr  output  1  out-of-range flag, valid with memAck.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, WAIT, DONE.
REQ-017 SHALL accept a request only in IDLE, when memCe=1 and (memWr|memRr)=1, and only on a rising edge.
REQ-018 SHALL capture memAddr, wtData, w_mask, r_mask and the op type on the accepting edge; later input changes do not affect the transaction.
REQ-019 SHALL treat memWr=memRr=1 as a write only, with no read performed and rdData unchanged.
REQ-020 SHALL go IDLE->WAIT on accept when WAIT_CYCLES>0, otherwise IDLE->DONE.
REQ-021 SHALL stay in WAIT for exactly WAIT_CYCLES cycles using a 4-bit down-counter, then go to DONE.
REQ-022 SHALL go DONE->IDLE unconditionally after one cycle.
REQ-023 SHALL ignore requests presented while in WAIT or DONE; they are not queued.
REQ-024 SHALL assert memAck=1 only in DONE, giving a request-accept-to-ack latency of WAIT_CYCLES+1 cycles.
REQ-025 SHALL assert memBusy=1 in WAIT and DONE and hold it 0 in IDLE.
REQ-026 SHALL select the word index from captured memAddr[ADDR_W+1:2] and ignore memAddr[1:0].
REQ-027 SHALL treat a request as out of range when any bit of captured memAddr[31:ADDR_W+2] is nonzero.
REQ-028 SHALL, for an out-of-range request, perform no array write, load rdData=0, and set memErr=1 in DONE.
REQ-029 SHALL, for an in-range write, update only the lanes whose w_mask bit is 1, on the edge entering DONE.
REQ-030 SHALL leave the array unchanged for a write with w_mask=0000, while still acknowledging it.
REQ-031 SHALL, for an in-range read, load rdData on the edge entering DONE, with each lane set to the array byte where r_mask=1 and 0x00 where r_mask=0.
REQ-032 SHALL hold rdData until the next completed read or reset; writes do not alter it.
REQ-033 SHALL make a read accepted in the IDLE cycle after a write's DONE return the newly written data.
REQ-034 SHALL hold memErr=0 outside DONE.

Reset
REQ-035 SHALL, while rst=0, immediately force state=IDLE, the counter to 0, rdData=0, memAck=0, memBusy=0 and memErr=0, independent of clk.
REQ-036 SHALL, on reset asserted mid-transaction, abort the transaction with no array write and no memAck.
REQ-037 SHALL NOT reset the memory array contents.

Verification
REQ-038 Bench SHALL cover: WAIT_CYCLES=1, write 0xDEADBEEF to addr 0x10 with w_mask=1111, then read with r_mask=1111 -> memAck on the 2nd cycle after each accept, rdData=0xDEADBEEF.
REQ-039 Bench SHALL cover: a byte write of 0x000000AA to addr 0x10 with w_mask=0001, then a read with r_mask=1111 -> rdData=0xDEADBEAA; the same read with r_mask=0011 -> 0x0000BEAA.
REQ-040 Bench SHALL cover: a read at addr 0x0000_1000 with ADDR_W=10 -> memErr=1 and rdData=0 in the ack cycle, and the array unchanged.
REQ-041 Bench SHALL cover: memWr=memRr=1 writing 0x12345678 to addr 0x20 -> write performed, rdData unchanged; a second request issued while memBusy=1 -> ignored, exactly one memAck.
REQ-042 Bench SHALL cover: a write to addr 0x30 with rst driven 0 while in WAIT -> outputs 0 immediately, no memAck; a following read of 0x30 returns the pre-reset contents.
REQ-043 Bench SHALL cover: WAIT_CYCLES=0, back-to-back reads -> memAck in the cycle after each accept, and accepts spaced 2 cycles apart.

Source files
------------

// File: rtl/data_mem.sv
// Word-addressed 32-bit data memory with byte-lane masks, a fixed number of wait states
// and a single-outstanding request handshake (accept -> wait -> ack).
//
// state  | meaning
// S_IDLE | ready; accepts a request when memCe and (memWr|memRr)
// S_WAIT | request captured; counting down WAIT_CYCLES wait states
// S_DONE | access done on the entering edge; memAck pulses, memErr valid
module data_mem #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memCe,
  input  logic        memWr,
  input  logic        memRr,
  input  logic [31:0] memAddr,
  input  logic [31:0] wtData,
  input  logic [3:0]  w_mask,
  input  logic [3:0]  r_mask,
  output logic [31:0] rdData,
  output logic        memAck,
  output logic        memBusy,
  output logic        memErr
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wmask_q, rmask_q;
  logic        wr_q, rd_q;
  logic        accept, enter_done;
  logic [31:0] op_addr, op_wdata;
  logic [3:0]  op_wmask, op_rmask;
  logic        op_wr, op_rd, op_oor;
  logic [ADDR_W-1:0] op_idx;
  logic [31:0] rd_word, rd_masked;
  logic        unused_addr_lsb;
  logic [31:0] mem [2**ADDR_W];

  assign accept = (state == S_IDLE) && memCe && (memWr || memRr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
      S_WAIT:  if (cnt == 4'd0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // DONE always returns to IDLE, so any transition into DONE is a fresh entry.
  assign enter_done = (state_nxt == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rmask_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else if (accept) begin
      cnt     <= (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
      addr_q  <= memAddr;
      wdata_q <= wtData;
      wmask_q <= w_mask;
      rmask_q <= r_mask;
      wr_q    <= memWr;
      rd_q    <= memRr & ~memWr;
    end else if (state == S_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // With zero wait states the access happens on the accepting edge, so use live inputs.
  always_comb begin
    op_addr  = addr_q;
    op_wdata = wdata_q;
    op_wmask = wmask_q;
    op_rmask = rmask_q;
    op_wr    = wr_q;
    op_rd    = rd_q;
    if (state == S_IDLE) begin
      op_addr  = memAddr;
      op_wdata = wtData;
      op_wmask = w_mask;
      op_rmask = r_mask;
      op_wr    = memWr;
      op_rd    = memRr & ~memWr;
    end
  end

  assign op_oor          = |op_addr[31:ADDR_W+2];
  assign op_idx          = op_addr[ADDR_W+1:2];
  assign unused_addr_lsb = ^op_addr[1:0];
  assign rd_word         = mem[op_idx];

  always_comb begin
    rd_masked = '0;
    for (int i = 0; i < 4; i++)
      if (op_rmask[i]) rd_masked[8*i +: 8] = rd_word[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst && enter_done && op_wr && !op_oor)
      for (int i = 0; i < 4; i++)
        if (op_wmask[i]) mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdData <= '0;
      memErr <= 1'b0;
    end else begin
      memErr <= enter_done && op_oor;
      if (enter_done) begin
        if (op_oor)     rdData <= '0;
        else if (op_rd) rdData <= rd_masked;
      end
    end
  end

  assign memAck  = (state == S_DONE);
  assign memBusy = (state != S_IDLE);

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: a vector table on a 1-wait-state instance plus
// hand-written sequences for dual requests, busy-time requests, mid-wait reset and 0-wait streaming.
module tb_data_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ce[2], wr[2], rd[2];
  logic [31:0] addr[2], wdata[2];
  logic [3:0]  wm[2], rm[2];
  logic [31:0] rdd[2];
  logic        ack[2], busy[2], err[2];

  int total = 0;
  int bad   = 0;

  data_mem #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst_n), .memCe(ce[0]), .memWr(wr[0]), .memRr(rd[0]),
    .memAddr(addr[0]), .wtData(wdata[0]), .w_mask(wm[0]), .r_mask(rm[0]),
    .rdData(rdd[0]), .memAck(ack[0]), .memBusy(busy[0]), .memErr(err[0])
  );

  data_mem #(.ADDR_W(10), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst_n), .memCe(ce[1]), .memWr(wr[1]), .memRr(rd[1]),
    .memAddr(addr[1]), .wtData(wdata[1]), .w_mask(wm[1]), .r_mask(rm[1]),
    .rdData(rdd[1]), .memAck(ack[1]), .memBusy(busy[1]), .memErr(err[1])
  );

  typedef struct {
    logic        w, r;
    logic [31:0] a, d;
    logic [3:0]  mw, mr;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  // Called at #1 after a rising edge with the target idle.
  task automatic go(input int s, input logic w, input logic r, input logic [31:0] a,
                    input logic [31:0] d, input logic [3:0] m_w, input logic [3:0] m_r,
                    input int lat, input logic [31:0] exp_rd, input logic exp_err,
                    input string name);
    int n;
    ce[s] = 1'b1; wr[s] = w; rd[s] = r; addr[s] = a; wdata[s] = d; wm[s] = m_w; rm[s] = m_r;
    @(posedge clk); #1;
    ce[s] = 1'b0; wr[s] = 1'b0; rd[s] = 1'b0;
    addr[s] = 32'hFFFF_FFFC; wdata[s] = 32'h5555_5555; wm[s] = 4'hF; rm[s] = 4'hF;
    chk({name, ".busy"}, 32'(busy[s]), 32'd1);
    n = 0;
    while (!ack[s] && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, ".lat"}, 32'(n), 32'(lat));
    chk({name, ".ack"}, 32'(ack[s]), 32'd1);
    chk({name, ".rd"}, rdd[s], exp_rd);
    chk({name, ".err"}, 32'(err[s]), 32'(exp_err));
    @(posedge clk); #1;
    chk({name, ".ack_off"}, 32'(ack[s]), 32'd0);
    chk({name, ".busy_off"}, 32'(busy[s]), 32'd0);
    chk({name, ".err_off"}, 32'(err[s]), 32'd0);
    chk({name, ".rd_hold"}, rdd[s], exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acks;
    logic [31:0] exp_stream[6];

    tbl[0]  = '{1'b1, 1'b0, 32'h10,   32'hDEAD_BEEF, 4'hF, 4'h0, 32'h0000_0000, 1'b0, "wr_full"};
    tbl[1]  = '{1'b0, 1'b1, 32'h10,   32'h0,         4'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, "rd_full"};
    tbl[2]  = '{1'b1, 1'b0, 32'h10,   32'h0000_00AA, 4'h1, 4'h0, 32'hDEAD_BEEF, 1'b0, "wr_byte"};
    tbl[3]  = '{1'b0, 1'b1, 32'h10,   32'h0,         4'h0, 4'hF, 32'hDEAD_BEAA, 1'b0, "rd_after_byte"};
    tbl[4]  = '{1'b0, 1'b1, 32'h10,   32'h0,         4'h0, 4'h3, 32'h0000_BEAA, 1'b0, "rd_mask3"};
    tbl[5]  = '{1'b1, 1'b0, 32'h10,   32'hFFFF_FFFF, 4'h0, 4'h0, 32'h0000_BEAA, 1'b0, "wr_mask0"};
    tbl[6]  = '{1'b0, 1'b1, 32'h13,   32'h0,         4'h0, 4'hF, 32'hDEAD_BEAA, 1'b0, "rd_lsb_ignored"};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,    32'h1111_1111, 4'hF, 4'h0, 32'hDEAD_BEAA, 1'b0, "wr_word0"};
    tbl[8]  = '{1'b0, 1'b1, 32'h1000, 32'h0,         4'h0, 4'hF, 32'h0000_0000, 1'b1, "rd_oor"};
    tbl[9]  = '{1'b1, 1'b0, 32'h1000, 32'hFFFF_FFFF, 4'hF, 4'h0, 32'h0000_0000, 1'b1, "wr_oor"};
    tbl[10] = '{1'b0, 1'b1, 32'h0,    32'h0,         4'h0, 4'hF, 32'h1111_1111, 1'b0, "rd_word0_kept"};
    tbl[11] = '{1'b0, 1'b1, 32'h10,   32'h0,         4'h0, 4'hC, 32'hDEAD_0000, 1'b0, "rd_maskC"};

    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      ce[s] = 1'b0; wr[s] = 1'b0; rd[s] = 1'b0;
      addr[s] = '0; wdata[s] = '0; wm[s] = '0; rm[s] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset.rd", rdd[s], 32'h0);
      chk("reset.ack", 32'(ack[s]), 32'd0);
      chk("reset.busy", 32'(busy[s]), 32'd0);
      chk("reset.err", 32'(err[s]), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      go(1, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].mw, tbl[i].mr, 1,
         tbl[i].exp_rd, tbl[i].exp_err, tbl[i].name);

    // Dual write+read request, with a second request held through WAIT and DONE.
    ce[1] = 1'b1; wr[1] = 1'b1; rd[1] = 1'b1; addr[1] = 32'h20;
    wdata[1] = 32'h1234_5678; wm[1] = 4'hF; rm[1] = 4'hF;
    @(posedge clk); #1;
    wr[1] = 1'b0; rd[1] = 1'b1; addr[1] = 32'h10; wdata[1] = 32'h0; wm[1] = 4'h0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ack[1]) acks++;
      if (i == 1) begin ce[1] = 1'b0; rd[1] = 1'b0; end
    end
    chk("dual.acks", 32'(acks), 32'd1);
    chk("dual.rd_unchanged", rdd[1], 32'hDEAD_0000);
    chk("dual.idle", 32'(busy[1]), 32'd0);
    go(1, 1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 4'hF, 1, 32'h1234_5678, 1'b0, "dual.readback");

    // Reset during WAIT aborts the write.
    go(1, 1'b1, 1'b0, 32'h30, 32'hCAFE_F00D, 4'hF, 4'h0, 1, 32'h1234_5678, 1'b0, "rst.pre_wr");
    go(1, 1'b0, 1'b1, 32'h30, 32'h0, 4'h0, 4'hF, 1, 32'hCAFE_F00D, 1'b0, "rst.pre_rd");
    ce[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h30; wdata[1] = 32'h0BAD_BAD0; wm[1] = 4'hF;
    @(posedge clk); #1;
    ce[1] = 1'b0; wr[1] = 1'b0;
    chk("rst.in_wait", 32'(busy[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.busy", 32'(busy[1]), 32'd0);
    chk("rst.ack", 32'(ack[1]), 32'd0);
    chk("rst.err", 32'(err[1]), 32'd0);
    chk("rst.rd", rdd[1], 32'h0);
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ack[1]) acks++;
    end
    chk("rst.no_ack", 32'(acks), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    go(1, 1'b0, 1'b1, 32'h30, 32'h0, 4'h0, 4'hF, 1, 32'hCAFE_F00D, 1'b0, "rst.post_rd");

    // Zero wait states: streaming reads accepted every other cycle.
    go(0, 1'b1, 1'b0, 32'h8, 32'hA5A5_5A5A, 4'hF, 4'h0, 0, 32'h0, 1'b0, "w0.wr8");
    go(0, 1'b1, 1'b0, 32'hC, 32'h0102_0304, 4'hF, 4'h0, 0, 32'h0, 1'b0, "w0.wrC");
    exp_stream[0] = 32'hA5A5_5A5A; exp_stream[2] = 32'h0102_0304; exp_stream[4] = 32'hA5A5_5A5A;
    ce[0] = 1'b1; rd[0] = 1'b1; addr[0] = 32'h8; rm[0] = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("w0.stream_ack%0d", i), 32'(ack[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) chk($sformatf("w0.stream_rd%0d", i), rdd[0], exp_stream[i]);
      if (i == 1) addr[0] = 32'hC;
      if (i == 3) addr[0] = 32'h8;
    end
    ce[0] = 1'b0; rd[0] = 1'b0;
    @(posedge clk); #1;
    chk("w0.stream_idle", 32'(busy[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
